// File: rtl/fwd_pkg.sv
// fwd_pkg: shared widths, pipeline tag type and FSM states for forward_ctrl
package fwd_pkg;
    localparam int REG_W = 3;
    localparam logic [REG_W-1:0] REG_ZERO = 3'd0;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             load;
    } tag_t;

    typedef enum logic {RUN, STALL} state_t;
endpackage

// File: rtl/fwd_match.sv
// fwd_match: producer tag vs source register compare; r0 never matches
//   tag - pipeline tag of a producing instruction
//   src - source register address of the decode instruction
//   hit - tag writes src and src is not r0
module fwd_match
    import fwd_pkg::*;
(
    input  tag_t             tag,
    input  logic [REG_W-1:0] src,
    output logic             hit
);
    assign hit = tag.valid & tag.wr & (tag.rd == src) & (src != REG_ZERO);
endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: EX/MEM forwarding selects and load-use stall for a 5-stage pipe
//   clk, rst (async, active high)
//   id_valid, id_rs, id_rt, id_rd, id_wr, id_load - decode instruction
//   flush - kill decode and EX instructions
//   One_A/One_B - forward EX/MEM result; Two_A/Two_B - forward MEM/WB result
//   stall - hold PC and decode register
//   stall_count, fwd_count - saturating perf counters, only with FWD_PERF_EN
module forward_ctrl
    import fwd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             flush,
    output logic             One_A,
    output logic             One_B,
    output logic             Two_A,
    output logic             Two_B,
    output logic             stall
`ifdef FWD_PERF_EN
   ,output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] fwd_count
`endif
);
    tag_t ex_tag, mem_tag, id_tag;
    state_t state, state_nx;
    logic ex_a, ex_b, mem_a, mem_b;
    logic [3:0] sel_d;

    assign id_tag = '{valid: id_valid, rd: id_rd, wr: id_wr, load: id_load};

    fwd_match u_ex_a  (.tag(ex_tag),  .src(id_rs), .hit(ex_a));
    fwd_match u_ex_b  (.tag(ex_tag),  .src(id_rt), .hit(ex_b));
    fwd_match u_mem_a (.tag(mem_tag), .src(id_rs), .hit(mem_a));
    fwd_match u_mem_b (.tag(mem_tag), .src(id_rt), .hit(mem_b));

    // A stall or flush pushes a bubble into EX, so nothing is forwarded to it.
    // EX is the younger producer and overrides MEM.
    always_comb begin
        stall    = (state == RUN) & id_valid & ex_tag.load & (ex_a | ex_b) & ~flush;
        state_nx = stall ? STALL : RUN;
        sel_d    = (flush | stall | ~id_valid) ? 4'b0
                 : {ex_a, mem_a & ~ex_a, ex_b, mem_b & ~ex_b};
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= RUN;
        else
            state <= state_nx;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ex_tag                     <= '0;
            mem_tag                    <= '0;
            {One_A, Two_A, One_B, Two_B} <= '0;
        end else begin
            mem_tag                    <= flush ? '0 : ex_tag;
            ex_tag                     <= (flush | stall) ? '0 : id_tag;
            {One_A, Two_A, One_B, Two_B} <= sel_d;
        end

`ifdef FWD_PERF_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (|sel_d && fwd_count != '1)
                fwd_count <= fwd_count + 1'b1;
        end
`endif
endmodule

// File: tb/tb_forward_ctrl.sv
// tb_forward_ctrl: directed and random checks of forward_ctrl against an instruction-level model
module tb_forward_ctrl;
    logic clk = 0, rst = 1;
    logic id_valid = 0, id_wr = 0, id_load = 0, flush = 0;
    logic [2:0] id_rs = 0, id_rt = 0, id_rd = 0;
    logic One_A, One_B, Two_A, Two_B, stall;
`ifdef FWD_PERF_EN
    logic [15:0] stall_count, fwd_count;
`endif

    forward_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .flush(flush),
        .One_A(One_A), .One_B(One_B), .Two_A(Two_A), .Two_B(Two_B), .stall(stall)
`ifdef FWD_PERF_EN
       ,.stall_count(stall_count), .fwd_count(fwd_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {bit v; logic [2:0] rd; bit wr; bit ld;} ins_t;
    localparam ins_t BUB = '{v: 0, rd: 0, wr: 0, ld: 0};

    ins_t ex, mem;
    bit was_stall, e_oa, e_ta, e_ob, e_tb;
    int e_sc, e_fc;
    int errs = 0, checks = 0;
    logic obs_stall;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 = no producer, 1 = youngest producer is in EX, 2 = in MEM
    function automatic int producer(input logic [2:0] s);
        if (s == 0) return 0;
        if (ex.v && ex.wr && ex.rd == s) return 1;
        if (mem.v && mem.wr && mem.rd == s) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        ex = BUB; mem = BUB; was_stall = 0;
        {e_oa, e_ta, e_ob, e_tb} = '0;
        e_sc = 0; e_fc = 0;
    endtask

    task automatic check_sel(input string pfx);
        check({pfx, "_One_A"}, One_A, e_oa);
        check({pfx, "_Two_A"}, Two_A, e_ta);
        check({pfx, "_One_B"}, One_B, e_ob);
        check({pfx, "_Two_B"}, Two_B, e_tb);
`ifdef FWD_PERF_EN
        check({pfx, "_stall_count"}, stall_count, e_sc[15:0]);
        check({pfx, "_fwd_count"}, fwd_count, e_fc[15:0]);
`endif
    endtask

    task automatic cyc(input bit v, input logic [2:0] rs, rt, rd, input bit wr, ld, fl);
        int pa, pb;
        bit e_stall;
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_wr = wr; id_load = ld; flush = fl;
        #1;
        pa = producer(rs);
        pb = producer(rt);
        e_stall = !was_stall && v && ex.ld && (pa == 1 || pb == 1) && !fl;
        obs_stall = stall;
        check("stall", stall, e_stall);
        if (fl) begin
            ex = BUB; mem = BUB; was_stall = 0;
            {e_oa, e_ta, e_ob, e_tb} = '0;
        end else if (e_stall) begin
            mem = ex; ex = BUB; was_stall = 1;
            {e_oa, e_ta, e_ob, e_tb} = '0;
            if (e_sc < 65535) e_sc++;
        end else begin
            e_oa = v && pa == 1; e_ta = v && pa == 2;
            e_ob = v && pb == 1; e_tb = v && pb == 2;
            mem = ex; ex = '{v: v, rd: rd, wr: wr, ld: ld}; was_stall = 0;
            if ((e_oa || e_ta || e_ob || e_tb) && e_fc < 65535) e_fc++;
        end
        @(posedge clk);
        #1;
        check_sel("sel");
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", stall, 0);
        check_sel("rst");
        @(negedge clk);
        rst = 0;

        // EX producer forwards on One_A
        cyc(1, 0, 0, 3, 1, 0, 0);
        cyc(1, 3, 0, 1, 0, 0, 0);
        check("ex_fwd_One_A", One_A, 1);
        check("ex_fwd_Two_A", Two_A, 0);

        // MEM producer forwards on Two_B, younger EX producer overrides it
        cyc(1, 0, 0, 5, 1, 0, 0);
        cyc(1, 0, 0, 2, 1, 0, 0);
        cyc(1, 0, 5, 1, 0, 0, 0);
        check("mem_fwd_Two_B", Two_B, 1);
        check("mem_fwd_One_B", One_B, 0);
        cyc(1, 0, 0, 5, 1, 0, 0);
        cyc(1, 0, 0, 5, 1, 0, 0);
        cyc(1, 0, 5, 1, 0, 0, 0);
        check("young_One_B", One_B, 1);
        check("young_Two_B", Two_B, 0);

        // load-use: one stall cycle, then forward from MEM
        cyc(1, 0, 0, 4, 1, 1, 0);
        cyc(1, 4, 0, 6, 1, 0, 0);
        check("lu_stall", obs_stall, 1);
        check("lu_bubble_One_A", One_A, 0);
        cyc(1, 4, 0, 6, 1, 0, 0);
        check("lu_held_stall", obs_stall, 0);
        check("lu_held_Two_A", Two_A, 1);
        check("lu_held_One_A", One_A, 0);

        // r0 never forwards
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 1, 0, 0);
        check("r0_One_A", One_A, 0);
        check("r0_Two_A", Two_A, 0);

        // flush beats load-use stall and bubbles both tags
        cyc(1, 0, 0, 4, 1, 1, 0);
        cyc(1, 4, 0, 6, 1, 0, 1);
        check("flush_stall", obs_stall, 0);
        check("flush_One_A", One_A, 0);
        cyc(1, 4, 0, 6, 1, 0, 0);
        check("post_flush_One_A", One_A, 0);
        check("post_flush_Two_A", Two_A, 0);

        repeat (1500)
            cyc($urandom_range(0, 7) != 0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                3'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);

        // fresh start: 3 load-use stalls, 5 forwards, then reset mid-stall
        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 4, 1, 1, 0);
            cyc(1, 4, 0, 0, 0, 0, 0);
            cyc(1, 4, 0, 0, 0, 0, 0);
        end
        cyc(1, 0, 0, 3, 1, 0, 0);
        cyc(1, 3, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 3, 1, 0, 0);
        cyc(1, 3, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 4, 1, 1, 0);
        @(negedge clk);
        id_valid = 1; id_rs = 4; id_rt = 0; id_rd = 0; id_wr = 0; id_load = 0; flush = 0;
        #1;
        check("pre_rst_stall", stall, 1);
`ifdef FWD_PERF_EN
        check("pre_rst_stall_count", stall_count, 3);
        check("pre_rst_fwd_count", fwd_count, 5);
`endif
        rst = 1;
        #1;
        model_reset();
        check("mid_rst_stall", stall, 0);
        check_sel("mid_rst");
        @(negedge clk);
        rst = 0;
        cyc(1, 4, 0, 0, 0, 0, 0);
        check("post_rst_One_A", One_A, 0);
        check("post_rst_Two_A", Two_A, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
